// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the execute stage and a
// byte-addressed data memory. One request is in flight at a time.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_we, req_funct3, req_addr,
//                          req_wdata are sampled on acceptance
//   resp_valid/resp_ready  response handshake; resp_rdata (load data, 0 for
//                          stores/errors), resp_err (misaligned/illegal funct3)
//   mem_WE, mem_A, mem_WD, mem_AddressingControl  memory drive, zero outside ACCESS
//   mem_RD                 combinational memory read data (already extended)
module lsu_mem_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_WE,
  output logic [XLEN-1:0] mem_A,
  output logic [XLEN-1:0] mem_WD,
  output logic [2:0]      mem_AddressingControl,
  input  logic [XLEN-1:0] mem_RD
);

  localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic accept;
  logic last_access;
  logic f3_illegal;
  logic misaligned;

  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign last_access = (state_q == ST_ACCESS) && (cnt_q == CNT_LAST);

  always_comb begin
    f3_illegal = 1'b1;
    if (req_we) begin
      if (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010)
        f3_illegal = 1'b0;
    end else begin
      if (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
          req_funct3 == 3'b100 || req_funct3 == 3'b101)
        f3_illegal = 1'b0;
    end
  end

  assign misaligned = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          // Bad requests skip ACCESS entirely so the memory never sees them.
          if (f3_illegal || misaligned) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
          if (!we_q) rdata_d = mem_RD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Write enable is gated by rst so an abort on the last access cycle cannot write.
  assign mem_WE                = last_access && we_q && !rst;
  assign mem_A                 = (state_q == ST_ACCESS) ? addr_q  : '0;
  assign mem_WD                = (state_q == ST_ACCESS) ? wdata_q : '0;
  assign mem_AddressingControl = (state_q == ST_ACCESS) ? f3_q    : '0;

endmodule
